reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- FIFO_DEPTH, 2, M-unit result buffer entries; legal values 2, 4 or 8.
- STARVE_LIMIT, 4, number of consecutive waiting cycles of the buffer head before stall_req asserts; legal range 1..15.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- pipe_wr_en, in, 1, main-pipeline writeback valid.
- pipe_wr_addr, in, 5, main-pipeline destination register.
- pipe_wr_data, in, 32, main-pipeline result.
- mdu_valid, in, 1, multicycle M-unit result valid.
- mdu_addr, in, 5, M-unit destination register.
- mdu_data, in, 32, M-unit result.
- mdu_ready, out, 1, M-unit result accepted this cycle.
- reg_file_wr_en, out, 1, register-file write enable (registered).
- reg_file_wr_addr, out, 5, register-file write address (registered).
- reg_file_wr_data, out, 32, register-file write data (registered).
- pending_rd_mask, out, 32, bitmap of destination registers held in the buffer.
- fifo_count, out, 4, number of occupied buffer entries.
- stall_req, out, 1, request for upstream to insert one writeback bubble.

Function
REQ-003 The block SHALL arbitrate the single register-file write port between the pipeline (fixed priority, never stalled) and the M-unit; every write appears on reg_file_wr_* exactly one cycle after its source is selected.

REQ-004 A pipe write is a pipe_wr_en=1 with pipe_wr_addr!=0; pipe_wr_en=1 with addr 0 SHALL produce no write.

REQ-005 mdu_ready SHALL equal (fifo_count<FIFO_DEPTH) combinationally; an M result is accepted when mdu_valid&&mdu_ready.

REQ-006 An accepted M result with mdu_addr=0 SHALL be discarded with no buffer entry and no write.

REQ-007 Per-cycle selection priority:
- (a) pipe write;
- (b) buffer head pop;
- (c) bypass — accepted M result written directly when the buffer is empty and there is no pipe write;
- (d) otherwise, push accepted M result.
- In cases (a) and (b), an accepted M result SHALL be pushed in the same cycle.

REQ-008 Push and pop in the same cycle with the buffer full SHALL be allowed only if mdu_ready was high, i.e. never from full; fifo_count changes by push-pop.

REQ-009 Buffer order SHALL be FIFO, using circular read/write pointers that wrap modulo FIFO_DEPTH.

REQ-010 Each entry SHALL carry a valid bit. A pipe write whose addr matches a buffered entry's addr SHALL clear that entry's valid bit in the same cycle, because the pipe result is younger.

REQ-011 Popping an invalidated head SHALL consume the pop slot, free the entry, and produce reg_file_wr_en=0 that cycle.

REQ-012 pending_rd_mask bit n SHALL be 1 iff a valid occupied entry has addr n; it SHALL be driven from registered state only, and bit 0 is always 0.

REQ-013 Starvation counter:
- 4-bit counter, increments each cycle the buffer is non-empty and the head is not popped;
- clears on pop or when the buffer is empty;
- saturates at 15.

REQ-014 stall_req SHALL be 1 iff starvation counter >= STARVE_LIMIT. A pipe write coinciding with stall_req still wins.

REQ-015 Simultaneous invalidation (REQ-010) and push of the same addr SHALL leave the newly pushed entry valid.

Reset
REQ-016 On rst=0, asynchronously and independent of clk, the block SHALL clear:
- reg_file_wr_en=0, reg_file_wr_addr=0, reg_file_wr_data=0;
- all entry valid bits, both pointers, fifo_count=0 and the starvation counter;
- which yields mdu_ready=1, pending_rd_mask=0, stall_req=0.

REQ-017 Reset asserted mid-operation SHALL discard all buffered results without any write; the first write after reset release SHALL occur no earlier than one cycle after the first rising clk edge with rst=1.

Verification
REQ-018 Bypass: idle, mdu_valid=1 addr 5 data 0x1234 → next cycle wr_en=1 addr 5 data 0x1234; fifo_count stays 0.

REQ-019 Conflict: pipe addr 3 data 0xA plus mdu addr 7 data 0xB in the same cycle → cycle+1 writes x3=0xA; cycle+2 writes x7=0xB; mask bit 7 is high for exactly one cycle.

REQ-020 Full and order (FIFO_DEPTH=2): pipe writes every cycle while mdu pushes addrs 8, 9 → fifo_count=2, mdu_ready=0. After pipe_wr_en drops, writes occur to x8 then x9, in order.

REQ-021 Invalidate: buffer holds addr 10; pipe writes addr 10 data 0x55 → the x10=0x55 write is the only write to x10; the later pop has wr_en=0.

REQ-022 Starvation (STARVE_LIMIT=4): head waits under continuous pipe writes → stall_req rises on the 4th waiting cycle and falls the cycle after the head pops.

REQ-023 Reset and x0: rst=0 with 2 buffered entries → all outputs at reset values immediately and no writes follow. An mdu result to addr 0 and pipe_wr_en with addr 0 → no write occurs.

Source files
------------

// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus between the pipeline, the M-unit and the register-file write port.
// The slave side is the arbiter; the master side drives the sources and observes the results.
interface reg_wb_arbiter_if;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_addr;
  logic [31:0] pipe_wr_data;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        reg_file_wr_en;
  logic [4:0]  reg_file_wr_addr;
  logic [31:0] reg_file_wr_data;
  logic [31:0] pending_rd_mask;
  logic [3:0]  fifo_count;
  logic        stall_req;

  modport slave (
    input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    input  mdu_valid, mdu_addr, mdu_data,
    output mdu_ready,
    output reg_file_wr_en, reg_file_wr_addr, reg_file_wr_data,
    output pending_rd_mask, fifo_count, stall_req
  );

  modport master (
    output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    output mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready,
    input  reg_file_wr_en, reg_file_wr_addr, reg_file_wr_data,
    input  pending_rd_mask, fifo_count, stall_req
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline always wins, M-unit results wait
// in a small FIFO whose entries are invalidated when the pipeline writes the same register.
module reg_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  reg_wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [3:0]            count_reg, count_next;
  logic [3:0]            starve_reg, starve_next;
  logic [FIFO_DEPTH-1:0] valid_reg, valid_next;
  logic [4:0]            addr_mem [FIFO_DEPTH];
  logic [31:0]           data_mem [FIFO_DEPTH];
  logic                  wr_en_reg, wr_en_next;
  logic [4:0]            wr_addr_reg, wr_addr_next;
  logic [31:0]           wr_data_reg, wr_data_next;

  logic        mdu_ready_int;
  logic        pipe_write, mdu_live, fifo_empty;
  logic        do_pop, do_bypass, do_push;
  logic [31:0] entry_mask [FIFO_DEPTH];
  logic [31:0] mask_or;

  assign fifo_empty    = (count_reg == 4'd0);
  assign mdu_ready_int = (count_reg < 4'(FIFO_DEPTH));
  assign pipe_write    = bus.pipe_wr_en && (bus.pipe_wr_addr != 5'd0);
  // Results to x0 are accepted but simply dropped.
  assign mdu_live      = bus.mdu_valid && mdu_ready_int && (bus.mdu_addr != 5'd0);
  assign do_pop        = !pipe_write && !fifo_empty;
  assign do_bypass     = !pipe_write && fifo_empty && mdu_live;
  assign do_push       = mdu_live && !do_bypass;

  always_comb begin
    valid_next = valid_reg;
    // The pipeline result is younger, so any buffered write to the same register is dead.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (pipe_write && (addr_mem[i] == bus.pipe_wr_addr)) valid_next[i] = 1'b0;
    end
    if (do_pop)  valid_next[rd_ptr_reg] = 1'b0;
    if (do_push) valid_next[wr_ptr_reg] = 1'b1;
  end

  always_comb begin
    rd_ptr_next = do_pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    wr_ptr_next = do_push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    count_next  = count_reg + 4'(do_push) - 4'(do_pop);
    if (fifo_empty || do_pop)    starve_next = 4'd0;
    else if (starve_reg != 4'd15) starve_next = starve_reg + 4'd1;
    else                          starve_next = starve_reg;
  end

  always_comb begin
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    if (pipe_write) begin
      wr_en_next   = 1'b1;
      wr_addr_next = bus.pipe_wr_addr;
      wr_data_next = bus.pipe_wr_data;
    end else if (do_pop) begin
      // An invalidated head still uses up the slot, but writes nothing.
      wr_en_next   = valid_reg[rd_ptr_reg];
      wr_addr_next = addr_mem[rd_ptr_reg];
      wr_data_next = data_mem[rd_ptr_reg];
    end else if (do_bypass) begin
      wr_en_next   = 1'b1;
      wr_addr_next = bus.mdu_addr;
      wr_data_next = bus.mdu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= 4'd0;
      starve_reg  <= 4'd0;
      valid_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= 5'd0;
      wr_data_reg <= 32'd0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      starve_reg  <= starve_next;
      valid_reg   <= valid_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr_reg] <= bus.mdu_addr;
      data_mem[wr_ptr_reg] <= bus.mdu_data;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mask
    assign entry_mask[gi] = valid_reg[gi] ? (32'd1 << addr_mem[gi]) : 32'd0;
  end

  always_comb begin
    mask_or = 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) mask_or = mask_or | entry_mask[i];
  end

  assign bus.mdu_ready        = mdu_ready_int;
  assign bus.pending_rd_mask  = {mask_or[31:1], 1'b0};
  assign bus.fifo_count       = count_reg;
  assign bus.stall_req        = (starve_reg >= 4'(STARVE_LIMIT));
  assign bus.reg_file_wr_en   = wr_en_reg;
  assign bus.reg_file_wr_addr = wr_addr_reg;
  assign bus.reg_file_wr_data = wr_data_reg;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts every register-file write
// and the status outputs; an independent monitor checks each write the DUT presents.
module tb_reg_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        valid;
  } ent_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   starve;
  ent_t buf_q[$];
  wr_t  exp_q[$];

  reg_wb_arbiter_if bus();

  reg_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = 32'd0;
    foreach (buf_q[i]) if (buf_q[i].valid) m[buf_q[i].addr] = 1'b1;
    return m;
  endfunction

  task automatic check_status();
    chk("fifo_count", 32'(bus.fifo_count), 32'(buf_q.size()));
    chk("mdu_ready", 32'(bus.mdu_ready), 32'(buf_q.size() < DEPTH));
    chk("pending_rd_mask", bus.pending_rd_mask, model_mask());
    chk("stall_req", 32'(bus.stall_req), 32'(starve >= LIMIT));
  endtask

  task automatic reset_checks();
    chk("rst_wr_en", 32'(bus.reg_file_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.reg_file_wr_addr), 32'd0);
    chk("rst_wr_data", bus.reg_file_wr_data, 32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_mdu_ready", 32'(bus.mdu_ready), 32'd1);
    chk("rst_mask", bus.pending_rd_mask, 32'd0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
  endtask

  task automatic drive(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bus.pipe_wr_en   = pe;
    bus.pipe_wr_addr = pa;
    bus.pipe_wr_data = pd;
    bus.mdu_valid    = mv;
    bus.mdu_addr     = ma;
    bus.mdu_data     = md;
  endtask

  // One clock of stimulus: check the state left by the last edge, apply inputs, advance the model.
  task automatic step(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md);
    logic pw, live, popped, was_empty;
    ent_t h;
    @(negedge clk);
    check_status();
    drive(pe, pa, pd, mv, ma, md);
    pw        = pe && (pa != 5'd0);
    live      = mv && (buf_q.size() < DEPTH) && (ma != 5'd0);
    was_empty = (buf_q.size() == 0);
    popped    = 1'b0;
    if (pw) begin
      exp_q.push_back('{pa, pd, cyc + 1});
      foreach (buf_q[i]) if (buf_q[i].addr == pa) buf_q[i].valid = 1'b0;
    end else if (!was_empty) begin
      h = buf_q.pop_front();
      popped = 1'b1;
      if (h.valid) exp_q.push_back('{h.addr, h.data, cyc + 1});
    end else if (live) begin
      exp_q.push_back('{ma, md, cyc + 1});
      live = 1'b0;
    end
    if (live) buf_q.push_back('{ma, md, 1'b1});
    if (was_empty || popped) starve = 0;
    else if (starve < 15)    starve = starve + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 5));
  endfunction

  task automatic rand_steps(input int n, input int p_pipe, input int p_mdu);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 99) < p_pipe, rand_addr(), $urandom(),
           $urandom_range(0, 99) < p_mdu, rand_addr(), $urandom());
  endtask

  // Monitor: every presented write must be the oldest predicted one, in the predicted cycle.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (bus.reg_file_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got x%0d=%h expected no write (cycle %0d)",
                   bus.reg_file_wr_addr, bus.reg_file_wr_data, cyc);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", 32'(bus.reg_file_wr_addr), 32'(w.addr));
          chk("wr_data", bus.reg_file_wr_data, w.data);
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    starve = 0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 reset_checks();
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;

    // Bypass into an empty buffer.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    idle(2);
    // Pipe and M-unit together: pipe first, M result one cycle later.
    step(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
    idle(2);
    // Fill the buffer under continuous pipe writes, hold long enough to starve, then drain.
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd8, 32'h88);
    step(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99);
    for (int i = 0; i < 6; i++) step(1'b1, 5'd4, 32'(i), 1'b1, 5'd12, 32'hDEAD);
    idle(4);
    // Invalidate a buffered entry with a younger pipe write.
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'h77);
    step(1'b1, 5'd10, 32'h55, 1'b0, 5'd0, 32'd0);
    idle(3);
    // Writes to x0 from either source produce nothing.
    step(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'hBAD);
    idle(2);

    // Reset mid-operation with two buffered entries.
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h8);
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 32'h9);
    step(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 reset_checks();
    buf_q.delete();
    starve = 0;
    drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd6, 32'h6);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    rand_steps(300, 50, 50);
    rand_steps(300, 90, 70);
    rand_steps(300, 15, 60);
    idle(12);
    @(negedge clk);
    chk("pending_writes_left", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
